// File: rtl/nes_poll_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : nes_poll_sequencer
// Brief    : Periodic NES controller poll: latch, 8-bit serial read, button
//            vector with new-press strobes. One instance per controller port.
// Revision : 1.0
// ============================================================================
module nes_poll_sequencer #(
    parameter int T_US6       = 152,
    parameter int POLL_CYCLES = 419583
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       nes_data,
    output logic       nes_latch,
    output logic       nes_pulse,
    output logic [7:0] buttons,
    output logic [7:0] press_edge,
    output logic       btn_valid,
    output logic       busy
);

    localparam int c_PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int c_SW = $clog2(T_US6);
    localparam logic [c_PW-1:0] c_POLL_LAST = c_PW'(POLL_CYCLES - 1);
    localparam logic [c_SW-1:0] c_SLOT_LAST = c_SW'(T_US6 - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LATCH = 3'd1,
        S_LOW   = 3'd2,
        S_PULSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_sync1;
    logic              r_ds;
    logic [c_PW-1:0]   r_poll;
    logic [c_SW-1:0]   r_slot;
    logic              r_half;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic              r_pending;
    logic              r_latch;
    logic              r_pulse;
    logic              r_busy;
    logic              r_valid;
    logic [7:0]        r_buttons;
    logic [7:0]        r_press;
    logic              w_poll_tick;
    logic              w_slot_end;
    logic              w_start;

    assign w_poll_tick = (r_poll == c_POLL_LAST);
    assign w_slot_end  = (r_slot == c_SLOT_LAST);
    assign w_start     = (r_state == S_IDLE) && (w_poll_tick || r_pending) && enable;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_LATCH;
            S_LATCH: if (w_slot_end && r_half) w_next = S_LOW;
            S_LOW:   if (w_slot_end) w_next = (r_bit_idx == 3'd7) ? S_DONE : S_PULSE;
            S_PULSE: if (w_slot_end) w_next = S_LOW;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Synchroniser idles high so a floating line reads as "released".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_ds    <= 1'b1;
        end else begin
            r_sync1 <= nes_data;
            r_ds    <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_poll    <= '0;
            r_pending <= 1'b0;
        end else begin
            r_poll <= w_poll_tick ? '0 : r_poll + c_PW'(1);
            if (w_start)
                r_pending <= 1'b0;
            else if (w_poll_tick && ((r_state != S_IDLE) || !enable))
                r_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_slot    <= '0;
            r_half    <= 1'b0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_slot <= '0;
                r_half <= 1'b0;
            end else begin
                r_slot <= w_slot_end ? '0 : r_slot + c_SW'(1);
                if ((r_state == S_LATCH) && w_slot_end)
                    r_half <= 1'b1;
            end
            if ((r_state == S_LATCH) && (w_next == S_LOW))
                r_bit_idx <= 3'd0;
            else if ((r_state == S_PULSE) && (w_next == S_LOW))
                r_bit_idx <= r_bit_idx + 3'd1;
            // First bit read (A) lands in the MSB.
            if ((r_state == S_LOW) && w_slot_end)
                r_shift[3'd7 - r_bit_idx] <= ~r_ds;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_latch   <= 1'b0;
            r_pulse   <= 1'b0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_buttons <= 8'h00;
            r_press   <= 8'h00;
        end else begin
            r_latch <= (w_next == S_LATCH);
            r_pulse <= (w_next == S_PULSE);
            r_busy  <= (w_next != S_IDLE);
            r_valid <= (r_state == S_DONE);
            if (r_state == S_DONE) begin
                r_buttons <= r_shift;
                r_press   <= r_shift & ~r_buttons;
            end else begin
                r_press   <= 8'h00;
            end
        end
    end

    assign nes_latch  = r_latch;
    assign nes_pulse  = r_pulse;
    assign busy       = r_busy;
    assign btn_valid  = r_valid;
    assign buttons    = r_buttons;
    assign press_edge = r_press;

endmodule
`default_nettype wire

// File: tb/tb_nes_poll_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_nes_poll_sequencer
// Brief    : Self-checking bench; a pin-following controller model drives
//            data and a scoreboard holds the expected button frames.
// Revision : 1.0
// ============================================================================
module tb_nes_poll_sequencer;

    localparam int T = 4;
    localparam int P = 200;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       nes_data;
    logic       nes_latch;
    logic       nes_pulse;
    logic [7:0] buttons;
    logic [7:0] press_edge;
    logic       btn_valid;
    logic       busy;

    nes_poll_sequencer #(.T_US6(T), .POLL_CYCLES(P)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .nes_data   (nes_data),
        .nes_latch  (nes_latch),
        .nes_pulse  (nes_pulse),
        .buttons    (buttons),
        .press_edge (press_edge),
        .btn_valid  (btn_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference poll phase: value of the poll counter during the current cycle.
    int mp;
    always @(posedge clk or posedge reset) begin
        if (reset) mp <= 0;
        else       mp <= (mp == P-1) ? 0 : mp + 1;
    end

    typedef struct packed {logic [7:0] b; logic [7:0] pe;} exp_t;
    typedef struct {
        int         waited;
        int         start_poll;
        int         latch_cyc;
        int         rises;
        int         high;
        int         vofs;
        logic [7:0] btn;
        logic [7:0] pe;
        logic       busy_v;
        logic       valid_after;
        logic [7:0] pe_after;
        bit         ok;
    } res_t;

    exp_t       sb[$];
    logic [7:0] model_btn;
    int         n_cmp = 0;
    int         n_bad = 0;

    // Expected frame; a toggle at slot cycle tat reaches the sampler only if
    // it precedes slot_end by at least the 2-cycle synchroniser latency.
    function automatic void expect_frame(input logic [7:0] pressed, input int tbit, input int tat);
        logic [7:0] s;
        exp_t       e;
        s = pressed;
        if (tbit >= 0 && tat <= T-3) s[7-tbit] = ~s[7-tbit];
        e.b  = s;
        e.pe = s & ~model_btn;
        model_btn = s;
        sb.push_back(e);
    endfunction

    task automatic serve_frame(input logic [7:0] pressed, input int tbit, input int tat, output res_t r);
        bit prev_p, in_low;
        int lj, idx;
        r.waited = 0; r.start_poll = -1; r.latch_cyc = 0; r.rises = 0; r.high = 0; r.vofs = -1;
        r.btn = 8'hxx; r.pe = 8'hxx; r.busy_v = 1'bx; r.valid_after = 1'bx; r.pe_after = 8'hxx; r.ok = 1;
        while (!nes_latch && r.waited < 3*P) begin
            @(negedge clk);
            r.waited++;
        end
        if (!nes_latch) begin
            r.ok = 0;
            return;
        end
        r.start_poll = mp;
        prev_p = 0; in_low = 0; lj = 0;
        for (int ofs = 0; ofs < 100; ofs++) begin
            if (btn_valid) begin
                r.vofs = ofs; r.btn = buttons; r.pe = press_edge; r.busy_v = busy;
                break;
            end
            if (nes_latch) r.latch_cyc++;
            if (nes_pulse) begin
                r.high++;
                if (!prev_p) r.rises++;
            end
            prev_p = nes_pulse;
            if (!nes_latch && !nes_pulse) begin
                lj     = in_low ? lj + 1 : 0;
                in_low = 1;
                idx    = (r.rises > 7) ? 7 : r.rises;
                nes_data = ~pressed[7-idx];
                if (idx == tbit && lj >= tat) nes_data = pressed[7-idx];
            end else begin
                in_low   = 0;
                nes_data = 1'b1;
            end
            @(negedge clk);
        end
        nes_data = 1'b1;
        if (r.vofs < 0) begin
            r.ok = 0;
            return;
        end
        @(negedge clk);
        r.valid_after = btn_valid;
        r.pe_after    = press_edge;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; nes_data = 1'b1; model_btn = 8'h00;
        #23;
        n_cmp++; if (nes_latch !== 1'b0)  begin n_bad++; $display("FAIL rst_latch: got %b want 0", nes_latch); end
        n_cmp++; if (nes_pulse !== 1'b0)  begin n_bad++; $display("FAIL rst_pulse: got %b want 0", nes_pulse); end
        n_cmp++; if (buttons !== 8'h00)   begin n_bad++; $display("FAIL rst_buttons: got %h want 00", buttons); end
        n_cmp++; if (press_edge !== 8'h00) begin n_bad++; $display("FAIL rst_press: got %h want 00", press_edge); end
        n_cmp++; if (btn_valid !== 1'b0)  begin n_bad++; $display("FAIL rst_valid: got %b want 0", btn_valid); end
        n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_first_frame();
        res_t r; exp_t e;
        expect_frame(8'h00, -1, 0);
        serve_frame(8'h00, -1, 0, r);
        e = sb.pop_front();
        n_cmp++; if (r.ok !== 1'b1)       begin n_bad++; $display("FAIL ff_timeout: got %b want 1", r.ok); end
        n_cmp++; if (r.waited !== P)      begin n_bad++; $display("FAIL ff_start_delay: got %0d want %0d", r.waited, P); end
        n_cmp++; if (r.start_poll !== 0)  begin n_bad++; $display("FAIL ff_start_phase: got %0d want 0", r.start_poll); end
        n_cmp++; if (r.latch_cyc !== 2*T) begin n_bad++; $display("FAIL ff_latch_len: got %0d want %0d", r.latch_cyc, 2*T); end
        n_cmp++; if (r.rises !== 7)       begin n_bad++; $display("FAIL ff_pulse_count: got %0d want 7", r.rises); end
        n_cmp++; if (r.high !== 7*T)      begin n_bad++; $display("FAIL ff_pulse_high: got %0d want %0d", r.high, 7*T); end
        n_cmp++; if (r.vofs !== 17*T+1)   begin n_bad++; $display("FAIL ff_valid_ofs: got %0d want %0d", r.vofs, 17*T+1); end
        n_cmp++; if (r.busy_v !== 1'b0)   begin n_bad++; $display("FAIL ff_busy_at_valid: got %b want 0", r.busy_v); end
        n_cmp++; if (r.btn !== e.b)       begin n_bad++; $display("FAIL ff_buttons: got %h want %h", r.btn, e.b); end
        n_cmp++; if (r.pe !== e.pe)       begin n_bad++; $display("FAIL ff_press: got %h want %h", r.pe, e.pe); end
        n_cmp++; if (r.valid_after !== 1'b0) begin n_bad++; $display("FAIL ff_valid_width: got %b want 0", r.valid_after); end
    endtask

    task automatic test_new_press();
        res_t r; exp_t e;
        for (int k = 0; k < 2; k++) begin
            expect_frame(8'h10, -1, 0);
            serve_frame(8'h10, -1, 0, r);
            e = sb.pop_front();
            n_cmp++; if (r.ok !== 1'b1)  begin n_bad++; $display("FAIL start_ok[%0d]: got %b want 1", k, r.ok); end
            n_cmp++; if (r.btn !== e.b)  begin n_bad++; $display("FAIL start_buttons[%0d]: got %h want %h", k, r.btn, e.b); end
            n_cmp++; if (r.pe !== e.pe)  begin n_bad++; $display("FAIL start_press[%0d]: got %h want %h", k, r.pe, e.pe); end
            n_cmp++; if (r.pe_after !== 8'h00) begin n_bad++; $display("FAIL start_press_clear[%0d]: got %h want 00", k, r.pe_after); end
        end
    endtask

    task automatic test_multi_button();
        res_t r; exp_t e;
        logic [7:0] pat [2];
        pat[0] = 8'h89; pat[1] = 8'h81;
        for (int k = 0; k < 2; k++) begin
            expect_frame(pat[k], -1, 0);
            serve_frame(pat[k], -1, 0, r);
            e = sb.pop_front();
            n_cmp++; if (r.ok !== 1'b1) begin n_bad++; $display("FAIL multi_ok[%0d]: got %b want 1", k, r.ok); end
            n_cmp++; if (r.btn !== e.b) begin n_bad++; $display("FAIL multi_buttons[%0d]: got %h want %h", k, r.btn, e.b); end
            n_cmp++; if (r.pe !== e.pe) begin n_bad++; $display("FAIL multi_press[%0d]: got %h want %h", k, r.pe, e.pe); end
        end
    endtask

    task automatic test_sync_latency();
        res_t r; exp_t e;
        for (int tat = T-2; tat >= T-3; tat--) begin
            expect_frame(8'h81, 1, tat);
            serve_frame(8'h81, 1, tat, r);
            e = sb.pop_front();
            n_cmp++; if (r.ok !== 1'b1) begin n_bad++; $display("FAIL sync_ok[%0d]: got %b want 1", tat, r.ok); end
            n_cmp++; if (r.btn !== e.b) begin n_bad++; $display("FAIL sync_buttons[%0d]: got %h want %h", tat, r.btn, e.b); end
            n_cmp++; if (r.pe !== e.pe) begin n_bad++; $display("FAIL sync_press[%0d]: got %h want %h", tat, r.pe, e.pe); end
        end
    endtask

    task automatic test_enable_gate();
        res_t r; exp_t e;
        int ticks, seen, guard;
        enable = 1'b0;
        ticks = 0; seen = 0; guard = 0;
        while (!(ticks >= 2 && mp == P/2) && guard < 3*P) begin
            @(negedge clk);
            guard++;
            if (mp == P-1) ticks++;
            if (nes_latch || busy) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL en_gated: got %0d busy cycles want 0", seen); end
        enable = 1'b1;
        @(negedge clk);
        n_cmp++; if (nes_latch !== 1'b1) begin n_bad++; $display("FAIL en_immediate: got %b want 1", nes_latch); end
        for (int k = 0; k < 2; k++) begin
            expect_frame(8'h24, -1, 0);
            serve_frame(8'h24, -1, 0, r);
            e = sb.pop_front();
            n_cmp++; if (r.ok !== 1'b1) begin n_bad++; $display("FAIL en_ok[%0d]: got %b want 1", k, r.ok); end
            n_cmp++; if (r.btn !== e.b) begin n_bad++; $display("FAIL en_buttons[%0d]: got %h want %h", k, r.btn, e.b); end
            n_cmp++; if (r.pe !== e.pe) begin n_bad++; $display("FAIL en_press[%0d]: got %h want %h", k, r.pe, e.pe); end
            if (k == 0) begin
                n_cmp++; if (r.start_poll === 0) begin n_bad++; $display("FAIL en_served_early: got phase %0d want nonzero", r.start_poll); end
            end else begin
                n_cmp++; if (r.start_poll !== 0) begin n_bad++; $display("FAIL en_next_on_tick: got phase %0d want 0", r.start_poll); end
                n_cmp++; if (r.waited <= 0)      begin n_bad++; $display("FAIL en_no_extra_frame: got wait %0d want >0", r.waited); end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        res_t r; exp_t e;
        int guard;
        guard = 0;
        while (!nes_pulse && guard < 3*P) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++; if (nes_pulse !== 1'b1) begin n_bad++; $display("FAIL rm_reach_pulse: got %b want 1", nes_pulse); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++; if (nes_latch !== 1'b0)   begin n_bad++; $display("FAIL rm_latch: got %b want 0", nes_latch); end
        n_cmp++; if (nes_pulse !== 1'b0)   begin n_bad++; $display("FAIL rm_pulse: got %b want 0", nes_pulse); end
        n_cmp++; if (busy !== 1'b0)        begin n_bad++; $display("FAIL rm_busy: got %b want 0", busy); end
        n_cmp++; if (btn_valid !== 1'b0)   begin n_bad++; $display("FAIL rm_valid: got %b want 0", btn_valid); end
        n_cmp++; if (buttons !== 8'h00)    begin n_bad++; $display("FAIL rm_buttons: got %h want 00", buttons); end
        model_btn = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        expect_frame(8'h10, -1, 0);
        serve_frame(8'h10, -1, 0, r);
        e = sb.pop_front();
        n_cmp++; if (r.ok !== 1'b1)      begin n_bad++; $display("FAIL rm_ok: got %b want 1", r.ok); end
        n_cmp++; if (r.waited !== P)     begin n_bad++; $display("FAIL rm_start_delay: got %0d want %0d", r.waited, P); end
        n_cmp++; if (r.start_poll !== 0) begin n_bad++; $display("FAIL rm_start_phase: got %0d want 0", r.start_poll); end
        n_cmp++; if (r.btn !== e.b)      begin n_bad++; $display("FAIL rm_buttons_after: got %h want %h", r.btn, e.b); end
        n_cmp++; if (r.pe !== e.pe)      begin n_bad++; $display("FAIL rm_press_after: got %h want %h", r.pe, e.pe); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_frame();
        test_new_press();
        test_multi_button();
        test_sync_latency();
        test_enable_gate();
        test_reset_mid_frame();
        n_cmp++; if (sb.size() !== 0) begin n_bad++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
